pkt_tx_framer: RTL and testbench
================================

Name: pkt_tx_framer

Overview:
- Transmit-side packetizer for the chiplet fabric.
- Accepts one request descriptor plus a stream of data words, and emits a complete packet as a flit stream: header, optional address, data, then CRC.
- The flit count always equals what the receive side computes from the header.
- Sits between an endpoint's request logic and its router/switch injection port.

Parameters:
- NODE_ID, 5'd0, source node id placed in flit metadata.req.
- DEFAULT_VC, 1'b0, vc used when req_vc_override is low.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  descriptor valid
- req_ready  out  1  descriptor accept
- req_fmt  in  4  format code
- req_dest  in  5  destination node id
- req_addr  in  32  byte address
- req_len  in  7  data word count (0 encodes the maximum)
- req_fst_b  in  4  first-word byte enables
- req_lst_b  in  4  last-word byte enables
- req_id  in  2  packet id
- req_vc_override  in  1  use req_vc instead of DEFAULT_VC
- req_vc  in  1  virtual channel
- data_valid  in  1  write data valid
- data_ready  out  1  write data accept
- data_word  in  32  write data
- flit_valid  out  1  output flit valid
- flit_ready  in  1  downstream accept
- flit_out  out  40  {vc, id[1:0], req[4:0], payload[31:0]}
- tx_busy  out  1  packet in progress
- pkt_sent  out  1  one-cycle pulse on CRC flit handshake
- fmt_err  out  1  one-cycle pulse when an unsupported format is dropped

Behaviour:
- Reset values: flit_valid=0, flit_out=0, req_ready=0 in the reset cycle and 1 after it (IDLE), data_ready=0, tx_busy=0, pkt_sent=0, fmt_err=0, state=IDLE, CRC=32'hFFFFFFFF.
- Reset mid-packet abandons the packet with no partial CRC flit emitted.
- Output register: flit_out and flit_valid are registered.
  - A new flit loads when load_ok = !flit_valid || flit_ready.
  - flit_out is held stable while flit_valid && !flit_ready.
- Metadata is latched at descriptor accept and constant for every flit of the packet.
- FSM states: IDLE, HDR, ADDR, DATA, CRC.
- IDLE:
  - req_ready=1; accept on req_valid.
  - Latch all descriptor fields.
  - Data count N: long formats use req_len, with 0 meaning 128; short formats use req_len[3:0], with 0 meaning 16.
  - Unsupported format: drop the descriptor, pulse fmt_err, stay in IDLE.
  - Otherwise go to HDR.
  - Supported formats: LONG_READ 0x0, LONG_WRITE 0x1, SHORT_READ 0x8, SHORT_WRITE 0x9.
- HDR (waits for load_ok):
  - Long header = {fmt, dest, 8'h00, lst_b, fst_b, req_len}.
  - Short header = {fmt, dest, req_addr[18:0], req_len[3:0]}.
  - Next state: long formats go to ADDR; SHORT_WRITE goes to DATA; SHORT_READ goes to CRC.
- ADDR: on load_ok, emit req_addr. LONG_WRITE then goes to DATA; LONG_READ goes to CRC.
- DATA:
  - data_ready = load_ok (combinational).
  - Each data_valid && data_ready loads data_word and decrements an 8-bit remaining counter.
  - On the last word, go to CRC.
- CRC:
  - On load_ok, emit the CRC word and go to IDLE.
  - pkt_sent pulses in the cycle the CRC flit handshakes, not when it loads.
- tx_busy=1 from accept until the CRC flit handshakes.
- req_ready is 0 until both state==IDLE and no CRC flit is pending.
- Latency: the header flit is valid in the cycle after accept. Back-to-back packets leave no bubble once the CRC flit is accepted.
- CRC arithmetic:
  - CRC-32, polynomial 0x04C11DB7, non-reflected, MSB-first, 32 bits per flit, no final XOR.
  - Init 32'hFFFFFFFF at accept.
  - Updated with every payload word as it loads into the output register; the CRC flit itself is excluded.
- Simultaneous events:
  - Descriptor accept and CRC handshake of the prior packet in the same cycle: not possible, because req_ready is low while a CRC flit is pending.
  - data_valid is ignored outside DATA.

Optional Feature:
- Macro: PKT_TX_CRC_EN.
- Defined: the CRC flit carries the CRC-32 described above.
- Undefined: the CRC logic is omitted and the CRC flit payload is 32'h00000000.
- Flit count and timing are identical in both builds.

Test Plan:
- LONG_READ, dest=3, fst_b=F, lst_b=0, len=0, addr=0x1000, flit_ready=1 → 3 flits: 0x01800780, 0x00001000, CRC; pkt_sent on the 3rd; metadata.req=NODE_ID on all flits.
- SHORT_WRITE, dest=2, addr=0x10, len=2, data 0xAAAA5555 then 0x12345678 → header 0x91000102, the 2 data words, CRC; total 4 flits.
- LONG_WRITE, len=0 → 131 flits; the remaining counter reaches 0 exactly at the 128th data word.
- Backpressure: flit_ready=0 for 5 cycles mid-DATA → flit_out stable, data_ready=0, no word lost or duplicated.
- req_fmt=0x3 → fmt_err pulses 1 cycle, no flit emitted, req_ready stays 1.
- rst asserted during DATA → the next cycle has flit_valid=0 and state IDLE; the next packet's CRC matches a golden model (no CRC carried over).

Source files
------------

// File: rtl/pkt_tx_framer.sv
// pkt_tx_framer: descriptor + write data -> header/addr/data/CRC flit stream.
// Define PKT_TX_CRC_EN to carry a real CRC-32 in the final flit (else zero).
module pkt_tx_framer #(
  parameter logic [4:0] NODE_ID    = 5'd0,
  parameter logic       DEFAULT_VC = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_fmt,
  input  logic [4:0]  req_dest,
  input  logic [31:0] req_addr,
  input  logic [6:0]  req_len,
  input  logic [3:0]  req_fst_b,
  input  logic [3:0]  req_lst_b,
  input  logic [1:0]  req_id,
  input  logic        req_vc_override,
  input  logic        req_vc,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data_word,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic [39:0] flit_out,
  output logic        tx_busy,
  output logic        pkt_sent,
  output logic        fmt_err
);

  localparam logic [3:0] F_LR = 4'h0;
  localparam logic [3:0] F_LW = 4'h1;
  localparam logic [3:0] F_SR = 4'h8;
  localparam logic [3:0] F_SW = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ADDR,
    S_DATA,
    S_CRC
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  meta_q, meta_d;
  logic [39:0] flit_q, flit_d;
  logic        fv_q, fv_d;
  logic        pend_q, pend_d;
  logic        ferr_q, ferr_d;

  logic        load_ok;
  logic        acc;
  logic        sup;
  logic        long_f;
  logic [31:0] hdr;
  logic [7:0]  n_words;
  logic [7:0]  meta_in;
  logic        ld;
  logic        crc_ld;
  logic [31:0] pay;
  logic [7:0]  meta_sel;

`ifdef PKT_TX_CRC_EN
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_base;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    end
    return r;
  endfunction
`endif

  always_comb begin
    load_ok = !fv_q || flit_ready;
    long_f  = !req_fmt[3];
    sup     = 1'b0;
    unique case (1'b1)
      req_fmt == F_LR: sup = 1'b1;
      req_fmt == F_LW: sup = 1'b1;
      req_fmt == F_SR: sup = 1'b1;
      req_fmt == F_SW: sup = 1'b1;
      default:         sup = 1'b0;
    endcase
    if (long_f) begin
      hdr = {req_fmt, req_dest, 8'h00,
             req_lst_b, req_fst_b, req_len};
      n_words = (req_len == 7'd0) ? 8'd128
                                  : {1'b0, req_len};
    end else begin
      hdr = {req_fmt, req_dest,
             req_addr[18:0], req_len[3:0]};
      n_words = (req_len[3:0] == 4'd0) ? 8'd16
                                       : {4'd0, req_len[3:0]};
    end
    meta_in = {req_vc_override ? req_vc : DEFAULT_VC,
               req_id, NODE_ID};
  end

  assign req_ready  = !rst && (state_q == S_IDLE) && !pend_q;
  assign acc        = req_valid && req_ready;
  assign data_ready = (state_q == S_DATA) && load_ok;
  assign flit_valid = fv_q;
  assign flit_out   = flit_q;
  assign tx_busy    = (state_q != S_IDLE) || pend_q;
  assign pkt_sent   = pend_q && fv_q && flit_ready;
  assign fmt_err    = ferr_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    meta_d  = meta_q;
    ld      = 1'b0;
    crc_ld  = 1'b0;
    pay     = 32'h0;
    ferr_d  = acc && !sup;
    unique case (state_q)
      S_IDLE: begin
        // The output register is free at accept, so HDR is
        // resolved here to put the header out the next cycle.
        if (acc && sup) begin
          wr_d    = req_fmt[0];
          addr_d  = req_addr;
          meta_d  = meta_in;
          rem_d   = n_words;
          ld      = 1'b1;
          pay     = hdr;
          state_d = long_f     ? S_ADDR :
                    req_fmt[0] ? S_DATA : S_CRC;
        end
      end
      S_HDR: begin
        state_d = S_IDLE;
      end
      S_ADDR: begin
        if (load_ok) begin
          ld      = 1'b1;
          pay     = addr_q;
          state_d = wr_q ? S_DATA : S_CRC;
        end
      end
      S_DATA: begin
        if (data_valid && load_ok) begin
          ld    = 1'b1;
          pay   = data_word;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (load_ok) begin
          ld      = 1'b1;
          crc_ld  = 1'b1;
          state_d = S_IDLE;
`ifdef PKT_TX_CRC_EN
          pay = crc_q;
`else
          pay = 32'h0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    meta_sel = acc ? meta_in : meta_q;
    flit_d   = ld ? {meta_sel, pay} : flit_q;
    fv_d     = ld ? 1'b1 : (flit_ready ? 1'b0 : fv_q);
    pend_d   = pend_q;
    if (pend_q && fv_q && flit_ready) pend_d = 1'b0;
    if (crc_ld) pend_d = 1'b1;

`ifdef PKT_TX_CRC_EN
    crc_base = (state_q == S_IDLE) ? 32'hFFFF_FFFF : crc_q;
    crc_d    = crc_q;
    if (ld && !crc_ld) crc_d = crc_step(crc_base, pay);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= 8'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      meta_q  <= 8'h0;
      flit_q  <= 40'h0;
      fv_q    <= 1'b0;
      pend_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef PKT_TX_CRC_EN
      crc_q   <= 32'hFFFF_FFFF;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      meta_q  <= meta_d;
      flit_q  <= flit_d;
      fv_q    <= fv_d;
      pend_q  <= pend_d;
      ferr_q  <= ferr_d;
`ifdef PKT_TX_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Bench for pkt_tx_framer: directed and random packets vs a flit-list model.
// Honours PKT_TX_CRC_EN for the expected CRC flit payload.
module tb_pkt_tx_framer;

  localparam logic [4:0] NID = 5'd7;
  localparam logic       DVC = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_fmt;
  logic [4:0]  req_dest;
  logic [31:0] req_addr;
  logic [6:0]  req_len;
  logic [3:0]  req_fst_b;
  logic [3:0]  req_lst_b;
  logic [1:0]  req_id;
  logic        req_vc_override;
  logic        req_vc;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_word;
  logic        flit_valid;
  logic        flit_ready;
  logic [39:0] flit_out;
  logic        tx_busy;
  logic        pkt_sent;
  logic        fmt_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hdr;

  pkt_tx_framer #(.NODE_ID(NID), .DEFAULT_VC(DVC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_dest(req_dest),
    .req_addr(req_addr), .req_len(req_len),
    .req_fst_b(req_fst_b), .req_lst_b(req_lst_b),
    .req_id(req_id), .req_vc_override(req_vc_override),
    .req_vc(req_vc),
    .data_valid(data_valid), .data_ready(data_ready),
    .data_word(data_word),
    .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_out(flit_out), .tx_busy(tx_busy),
    .pkt_sent(pkt_sent), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

`ifdef PKT_TX_CRC_EN
  logic [31:0] crc_tbl [256];

  task automatic build_tbl();
    for (int v = 0; v < 256; v++) begin
      logic [31:0] r;
      r = 32'(v) << 24;
      for (int k = 0; k < 8; k++)
        r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
      crc_tbl[v] = r;
    end
  endtask

  // Byte-table CRC-32, MSB first, init all-ones, no final XOR.
  function automatic logic [31:0] model_crc(input logic [31:0] w[$]);
    logic [31:0] c;
    logic [7:0]  idx;
    c = 32'hFFFF_FFFF;
    foreach (w[i]) begin
      for (int b = 3; b >= 0; b--) begin
        idx = c[31:24] ^ w[i][8*b +: 8];
        c = (c << 8) ^ crc_tbl[idx];
      end
    end
    return c;
  endfunction
`endif

  // mode 0: always ready, 1: random ready/valid, 2: 5-cycle stall
  task automatic run_pkt(input logic [3:0] fmt, input logic [4:0] dest,
                         input logic [31:0] addr, input logic [6:0] len,
                         input logic [3:0] fb, input logic [3:0] lb,
                         input logic [1:0] id, input logic ovr,
                         input logic vc, input int mode,
                         input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] words[$];
    logic [31:0] pays[$];
    logic [39:0] expq[$];
    logic [7:0]  meta;
    logic [31:0] crc;
    logic        lng, wr, got, hold;
    logic [39:0] pf;
    int n, di, cyc, nexp, nflit;
    lng  = !fmt[3];
    wr   = fmt[0];
    meta = {ovr ? vc : DVC, id, NID};
    if (lng) n = (len == 0) ? 128 : int'(len);
    else     n = (len[3:0] == 0) ? 16 : int'(len[3:0]);
    if (lng) pays.push_back({fmt, dest, 8'h00, lb, fb, len});
    else     pays.push_back({fmt, dest, addr[18:0], len[3:0]});
    if (lng) pays.push_back(addr);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        words.push_back(i == 0 ? w0 : i == 1 ? w1 : $urandom);
        pays.push_back(words[i]);
      end
    end
`ifdef PKT_TX_CRC_EN
    crc = model_crc(pays);
`else
    crc = 32'h0;
`endif
    foreach (pays[i]) expq.push_back({meta, pays[i]});
    expq.push_back({meta, crc});
    nexp = expq.size();

    req_fmt = fmt; req_dest = dest; req_addr = addr;
    req_len = len; req_fst_b = fb; req_lst_b = lb;
    req_id = id; req_vc_override = ovr; req_vc = vc;
    req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("accept", got, 1);
    if (!got) return;

    di = 0; cyc = 0; hold = 1'b0; pf = '0; nflit = 0;
    while (expq.size() > 0 && cyc < 4000) begin
      if (mode == 0)      flit_ready = 1'b1;
      else if (mode == 1) flit_ready = ($urandom_range(0, 3) != 0);
      else                flit_ready = !(cyc >= 4 && cyc < 9);
      data_valid = wr && di < n &&
                   (mode != 1 || $urandom_range(0, 2) != 0);
      data_word = (wr && di < n) ? words[di] : $urandom;
      @(negedge clk);
      if (cyc == 0) begin
        chk("hdr_latency", flit_valid, 1);
        chk("hdr_flit", flit_out, expq[0]);
        last_hdr = flit_out[31:0];
      end
      if (hold) chk("hold_stable", flit_out, pf);
      if (flit_valid && !flit_ready) chk("bp_data_ready", data_ready, 0);
      if (wr && di == n) chk("data_ready_done", data_ready, 0);
      if (flit_valid && flit_ready) begin
        nflit++;
        chk("flit", flit_out, expq.pop_front());
        chk("pkt_sent", pkt_sent, expq.size() == 0);
      end
      if (data_valid && data_ready) di++;
      hold = flit_valid && !flit_ready;
      pf = flit_out;
      @(posedge clk); #1;
      cyc++;
    end
    data_valid = 1'b0;
    chk("flit_count", nflit, nexp);
    chk("words_used", di, wr ? n : 0);
    @(negedge clk);
    chk("idle_valid", flit_valid, 0);
    chk("idle_busy", tx_busy, 0);
    chk("idle_ready", req_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] fl [4];
    fl = '{4'h0, 4'h1, 4'h8, 4'h9};
`ifdef PKT_TX_CRC_EN
    build_tbl();
`endif
    rst = 1'b1; req_valid = 1'b0; req_fmt = '0; req_dest = '0;
    req_addr = '0; req_len = '0; req_fst_b = '0; req_lst_b = '0;
    req_id = '0; req_vc_override = 1'b0; req_vc = 1'b0;
    data_valid = 1'b0; data_word = '0; flit_ready = 1'b0;
    last_hdr = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_flit_valid", flit_valid, 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    chk("rst_fmt_err", fmt_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    @(posedge clk); #1;

    run_pkt(4'h0, 5'd3, 32'h1000, 7'd0, 4'hF, 4'h0, 2'd1, 1'b0, 1'b0,
            0, 32'h0, 32'h0);
    chk("tp_lr_hdr", last_hdr, 32'h0180_0780);

    run_pkt(4'h9, 5'd2, 32'h10, 7'd2, 4'h0, 4'h0, 2'd2, 1'b1, 1'b0,
            0, 32'hAAAA_5555, 32'h1234_5678);
    chk("tp_sw_hdr", last_hdr, 32'h9100_0102);

    run_pkt(4'h1, 5'd9, $urandom, 7'd0, 4'h3, 4'hC, 2'd3, 1'b1, 1'b1,
            0, $urandom, $urandom);
    run_pkt(4'h9, 5'd5, $urandom, 7'd8, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0,
            2, $urandom, $urandom);
    run_pkt(4'h1, 5'd1, $urandom, 7'd6, 4'hF, 4'hF, 2'd1, 1'b0, 1'b0,
            2, $urandom, $urandom);

    // Unsupported format is dropped with a single fmt_err pulse.
    req_fmt = 4'h3; req_valid = 1'b1;
    @(negedge clk);
    chk("bad_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bad_fmt_err", fmt_err, 1);
    chk("bad_no_flit", flit_valid, 0);
    chk("bad_ready_kept", req_ready, 1);
    chk("bad_not_busy", tx_busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bad_fmt_err_end", fmt_err, 0);
    chk("bad_no_flit2", flit_valid, 0);
    @(posedge clk); #1;

    // Reset in the middle of a data phase.
    req_fmt = 4'h9; req_dest = 5'd4; req_addr = $urandom;
    req_len = 7'd10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flit_ready = 1'b1;
    data_valid = 1'b1; data_word = $urandom;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", flit_valid, 0);
    chk("post_rst_idle", req_ready, 1);
    chk("post_rst_busy", tx_busy, 0);
    @(posedge clk); #1;
    run_pkt(4'h9, 5'd6, $urandom, 7'd3, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0,
            0, $urandom, $urandom);

    for (int p = 0; p < 14; p++) begin
      run_pkt(fl[$urandom_range(0, 3)], 5'($urandom), $urandom,
              7'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
              $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
